// File: rtl/processor_hazard_unit.sv
// Load-use / taken-branch hazard detector driving PC, IF/ID and ID/EX controls.
// Optional perf counters (stall_count, flush_count) when HAZARD_PERF_CNT_EN is defined.
module processor_hazard_unit #(
    parameter int LOAD_STALL_CYCLES   = 1,
    parameter int BRANCH_FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ID_instruction,
    input  logic        Reg2Loc,
    input  logic [4:0]  EX_Rd,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic        EX_RegWrite,
    input  logic        branch_taken,
    output logic        pc_write_en,
    output logic        ifid_write_en,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic [1:0]  hazard_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] BF_RELOAD = 3'(BRANCH_FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic [4:0] rn, rm, rd, src2;
    logic       ex_is_load, load_use;
    logic       stall, flush;

    wire unused_bits = ^{ID_instruction[31:21], ID_instruction[15:10]};

    assign rn   = ID_instruction[9:5];
    assign rm   = ID_instruction[20:16];
    assign rd   = ID_instruction[4:0];
    assign src2 = Reg2Loc ? rm : rd;

    assign ex_is_load = EX_MemRead & EX_RegWrite & ~EX_MemWrite;
    assign load_use   = ex_is_load & (EX_Rd != 5'd31)
                      & ((EX_Rd == rn) | (EX_Rd == src2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    if (BF_RELOAD != 3'd0) begin
                        state_d = FLUSH;
                        cnt_d   = BF_RELOAD;
                    end
                end else if (load_use && LS_RELOAD != 3'd0) begin
                    state_d = STALL;
                    cnt_d   = LS_RELOAD;
                end
            end
            STALL, FLUSH: begin
                // A taken branch discards the (younger) stalled instruction.
                if (branch_taken) begin
                    state_d = (BF_RELOAD != 3'd0) ? FLUSH : RUN;
                    cnt_d   = BF_RELOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1)
                        state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_comb begin
        stall = ~reset & (((state_q == RUN) & load_use & ~branch_taken)
                          | (state_q == STALL));
        flush = ~reset & (branch_taken | (state_q == FLUSH));
    end

    assign pc_write_en   = flush | ~stall;
    assign ifid_write_en = flush | ~stall;
    assign idex_bubble   = stall | flush;
    assign ifid_flush    = flush;
    assign hazard_state  = reset ? 2'b00 : state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 32'd0;
            flush_count <= 32'd0;
        end else begin
            if (stall && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
            if (flush && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_processor_hazard_unit.sv
// Bench for processor_hazard_unit: directed hazard cases then random traffic,
// two instances (1/1 and 3/2 cycle parameters) checked against a cycle-budget model.
module tb_processor_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ID_instruction;
    logic        Reg2Loc;
    logic [4:0]  EX_Rd;
    logic        EX_MemRead, EX_MemWrite, EX_RegWrite;
    logic        branch_taken;

    logic [1:0]  pwe, iwe, bub, ifl;
    logic [1:0]  hs0, hs1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc0, sc1, fc0, fc1;
`endif

    int n_vec = 0;
    int n_err = 0;

    int ls [2] = '{1, 3};
    int bf [2] = '{1, 2};
    int sl [2] = '{0, 0};
    int fl [2] = '{0, 0};
    longint m_sc [2] = '{0, 0};
    longint m_fc [2] = '{0, 0};

    always #5 clk = ~clk;

    processor_hazard_unit u_a (
        .clk(clk), .reset(reset), .ID_instruction(ID_instruction),
        .Reg2Loc(Reg2Loc), .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_RegWrite(EX_RegWrite),
        .branch_taken(branch_taken), .pc_write_en(pwe[0]),
        .ifid_write_en(iwe[0]), .idex_bubble(bub[0]),
        .ifid_flush(ifl[0]), .hazard_state(hs0)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(sc0), .flush_count(fc0)
`endif
    );

    processor_hazard_unit #(
        .LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2)
    ) u_b (
        .clk(clk), .reset(reset), .ID_instruction(ID_instruction),
        .Reg2Loc(Reg2Loc), .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_RegWrite(EX_RegWrite),
        .branch_taken(branch_taken), .pc_write_en(pwe[1]),
        .ifid_write_en(iwe[1]), .idex_bubble(bub[1]),
        .ifid_flush(ifl[1]), .hazard_state(hs1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_count(sc1), .flush_count(fc1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int rn, input int rm,
                                       input int rd);
        logic [31:0] w;
        w = $urandom;
        w[9:5]   = 5'(rn);
        w[20:16] = 5'(rm);
        w[4:0]   = 5'(rd);
        return w;
    endfunction

    // Hazard exists when a real load (not store, not to XZR) writes a register the ID instruction reads.
    function automatic bit hazard(input logic [31:0] ins, input logic r2l,
                                  input logic [4:0] exrd, input logic mr,
                                  input logic mw, input logic rw);
        int rn, src;
        rn  = int'(ins[9:5]);
        src = r2l ? int'(ins[20:16]) : int'(ins[4:0]);
        if (!(mr && rw && !mw)) return 0;
        if (exrd == 5'd31) return 0;
        return (int'(exrd) == rn) || (int'(exrd) == src);
    endfunction

    task automatic step(input logic rst, input logic [31:0] ins,
                        input logic r2l, input logic [4:0] exrd,
                        input logic mr, input logic mw, input logic rw,
                        input logic bt);
        bit lu, e_st, e_fl, e_pwe, e_bub;
        int e_hs;
        logic [1:0] hs;
        string p;
        reset = rst; ID_instruction = ins; Reg2Loc = r2l; EX_Rd = exrd;
        EX_MemRead = mr; EX_MemWrite = mw; EX_RegWrite = rw;
        branch_taken = bt;
        #1;
        lu = hazard(ins, r2l, exrd, mr, mw, rw);
        for (int k = 0; k < 2; k++) begin
            p = (k == 0) ? "a." : "b.";
            hs = (k == 0) ? hs0 : hs1;
            e_fl = !rst && (bt || fl[k] > 0);
            e_st = !rst && (sl[k] > 0 ||
                            (sl[k] == 0 && fl[k] == 0 && lu && !bt));
            e_pwe = e_fl || !e_st;
            e_bub = e_st || e_fl;
            e_hs  = rst ? 0 : (fl[k] > 0 ? 2 : (sl[k] > 0 ? 1 : 0));
            check({p, "pc_write_en"},   32'(pwe[k]), 32'(e_pwe));
            check({p, "ifid_write_en"}, 32'(iwe[k]), 32'(e_pwe));
            check({p, "idex_bubble"},   32'(bub[k]), 32'(e_bub));
            check({p, "ifid_flush"},    32'(ifl[k]), 32'(e_fl));
            check({p, "hazard_state"},  32'(hs),     32'(e_hs));
`ifdef HAZARD_PERF_CNT_EN
            check({p, "stall_count"}, (k == 0) ? sc0 : sc1, 32'(m_sc[k]));
            check({p, "flush_count"}, (k == 0) ? fc0 : fc1, 32'(m_fc[k]));
`endif
            if (rst) begin
                sl[k] = 0; fl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                if (e_st && m_sc[k] < 64'hFFFF_FFFF) m_sc[k]++;
                if (e_fl && m_fc[k] < 64'hFFFF_FFFF) m_fc[k]++;
                if (bt) begin
                    fl[k] = bf[k] - 1; sl[k] = 0;
                end else if (fl[k] > 0) begin
                    fl[k]--;
                end else if (sl[k] > 0) begin
                    sl[k]--;
                end else if (lu) begin
                    sl[k] = ls[k] - 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        step(1, mk(0, 0, 0), 0, 0, 0, 0, 0, 0);
        step(1, mk(0, 0, 0), 0, 0, 0, 0, 0, 0);
        // load-use on Rn, then EX bubble
        step(0, mk(5, 1, 2), 1, 5, 1, 0, 1, 0);
        step(0, mk(5, 1, 2), 1, 5, 0, 0, 0, 0);
        step(0, mk(5, 1, 2), 1, 5, 0, 0, 0, 0);
        step(0, mk(5, 1, 2), 1, 5, 0, 0, 0, 0);
        // Reg2Loc selects Rm vs Rd
        step(0, mk(1, 7, 3), 1, 7, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, mk(1, 7, 3), 1, 7, 0, 0, 0, 0);
        step(0, mk(1, 7, 3), 0, 7, 1, 0, 1, 0);
        step(0, mk(31, 2, 3), 1, 31, 1, 0, 1, 0);
        // store and ALU producer never stall
        step(0, mk(4, 1, 2), 1, 4, 1, 1, 0, 0);
        step(0, mk(4, 1, 2), 1, 4, 0, 0, 1, 0);
        // load-use coinciding with a taken branch
        step(0, mk(6, 6, 6), 1, 6, 1, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(0, mk(1, 2, 3), 1, 9, 0, 0, 0, 0);
        // reset in cycle 2 of the 3-cycle stall
        step(0, mk(8, 1, 2), 1, 8, 1, 0, 1, 0);
        step(1, mk(8, 1, 2), 1, 8, 0, 0, 0, 0);
        step(0, mk(1, 2, 3), 1, 9, 0, 0, 0, 0);
        step(0, mk(8, 1, 2), 1, 8, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(0, mk(1, 2, 3), 1, 9, 0, 0, 0, 0);
        // branch during a stall
        step(0, mk(8, 1, 2), 1, 8, 1, 0, 1, 0);
        step(0, mk(1, 2, 3), 1, 9, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, mk(1, 2, 3), 1, 9, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 49) == 0,
                 mk(pick_reg(), pick_reg(), pick_reg()),
                 1'($urandom), pick_reg(),
                 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
